loop_limit_mc: RTL and testbench

//  Multi-channel successor of the single-counter loop limiter in the hash performance path.

---
 rtl/loop_limit_pkg.sv | 22 ++
 rtl/loop_limit_chan.sv | 112 +++++++++++
 rtl/loop_limit_mc.sv | 82 ++++++++
 tb/tb_loop_limit_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/loop_limit_pkg.sv
// Shared definitions for the multi-channel hash-round loop limiter.
//   ll_state_e        : per-channel state encoding (IDLE/RUN/FAIL), fixed here
//                       so every channel and any checker agree on the values.
//   fail_first_width  : bit width of the lowest-failing-channel index output.
package loop_limit_pkg;

  typedef enum logic [1:0] {
    LL_IDLE = 2'b00,
    LL_RUN  = 2'b01,
    LL_FAIL = 2'b10
  } ll_state_e;

  // Index width for fail_first; a single channel still gets one bit.
  function automatic int fail_first_width(input int channels);
    if (channels <= 1) begin
      return 1;
    end else begin
      return $clog2(channels);
    end
  endfunction

endpackage

// File: rtl/loop_limit_chan.sv
// One loop-limit channel: counter, IDLE/RUN/FAIL state machine and the
// overrun compare against the shared limit.
// Ports:
//   clk         in   clock, all state on posedge
//   reset       in   synchronous active-high reset
//   stop        in   freezes the counter and the compare while in RUN
//   limit       in   shared runtime limit, sampled every cycle
//   load        in   load strobe (highest priority after reset)
//   seed        in   load value
//   clear_fail  in   return to IDLE with count 0 (ignored when load is set)
//   count       out  live count
//   fail        out  registered overrun flag, equal to (state == FAIL)
module loop_limit_chan
  import loop_limit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             clear_fail,
  output logic [WIDTH-1:0] count,
  output logic             fail
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  ll_state_e        state_r;
  ll_state_e        state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             fail_r;
  logic             fail_nxt_s;
  logic [WIDTH:0]   sum_s;

  // State, count and fail flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LL_IDLE;
      count_r <= {WIDTH{1'b0}};
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      fail_r  <= fail_nxt_s;
    end
  end

  // Next state and count: load > clear_fail > stop > count/compare.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    // One extra bit so the increment can be clamped instead of wrapping.
    sum_s       = {1'b0, count_r} + STEP_EXT;
    if (load) begin
      if (seed > limit) begin
        state_nxt_s = LL_FAIL;
        count_nxt_s = limit;
      end else begin
        state_nxt_s = LL_RUN;
        count_nxt_s = seed;
      end
    end else if (clear_fail) begin
      state_nxt_s = LL_IDLE;
      count_nxt_s = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        LL_IDLE: begin
          state_nxt_s = LL_IDLE;
          count_nxt_s = {WIDTH{1'b0}};
        end
        LL_RUN: begin
          if (stop) begin
            state_nxt_s = LL_RUN;
            count_nxt_s = count_r;
          end else if (count_r >= limit) begin
            // Count is held, even if a lowered limit left it above the limit.
            state_nxt_s = LL_FAIL;
            count_nxt_s = count_r;
          end else if (sum_s > {1'b0, limit}) begin
            state_nxt_s = LL_RUN;
            count_nxt_s = limit;
          end else begin
            state_nxt_s = LL_RUN;
            count_nxt_s = sum_s[WIDTH-1:0];
          end
        end
        LL_FAIL: begin
          state_nxt_s = LL_FAIL;
          count_nxt_s = count_r;
        end
        default: begin
          // A corrupted state code is reported as an overrun rather than hidden.
          state_nxt_s = LL_FAIL;
          count_nxt_s = count_r;
        end
      endcase
    end
    fail_nxt_s = (state_nxt_s == LL_FAIL);
  end

  // Outputs come straight from registers.
  always_comb begin
    count = count_r;
    fail  = fail_r;
  end

endmodule

// File: rtl/loop_limit_mc.sv
// Multi-channel hash-round loop limiter. CHANNELS independent counters, each
// seeded by its own load strobe, all compared against one shared limit. A
// channel that overruns raises a sticky fail; the lowest failing channel index
// is reported on fail_first.
// Ports:
//   clk                     in   clock
//   reset                   in   synchronous active-high reset
//   stop                    in   global freeze of all RUN counters
//   limit                   in   shared runtime limit
//   load                    in   per-channel load strobe
//   current_loop            in   per-channel seed, channel i at [i*WIDTH +: WIDTH]
//   clear_fail              in   per-channel fail clear (to IDLE, count 0)
//   current_loop_actualize  out  per-channel live count, same packing
//   fail                    out  sticky per-channel overrun flag
//   fail_any                out  OR of fail
//   fail_first              out  lowest index with fail set, 0 when none
module loop_limit_mc
  import loop_limit_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1,
  localparam int FF_W    = fail_first_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stop,
  input  logic [WIDTH-1:0]          limit,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] current_loop,
  input  logic [CHANNELS-1:0]       clear_fail,
  output logic [CHANNELS*WIDTH-1:0] current_loop_actualize,
  output logic [CHANNELS-1:0]       fail,
  output logic                      fail_any,
  output logic [FF_W-1:0]           fail_first
);

  logic [WIDTH-1:0]    count_s [CHANNELS];
  logic [CHANNELS-1:0] fail_s;
  logic [FF_W-1:0]     fail_first_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    loop_limit_chan #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .stop       (stop),
      .limit      (limit),
      .load       (load[i]),
      .seed       (current_loop[i*WIDTH +: WIDTH]),
      .clear_fail (clear_fail[i]),
      .count      (count_s[i]),
      .fail       (fail_s[i])
    );
  end

  // Pack the per-channel counts into the flat output bus.
  always_comb begin
    current_loop_actualize = {(CHANNELS*WIDTH){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      current_loop_actualize[i*WIDTH +: WIDTH] = count_s[i];
    end
  end

  // Lowest-index priority encoder: scan downward so the lowest set bit wins.
  always_comb begin
    fail_first_s = {FF_W{1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      fail_first_s = fail_s[i] ? FF_W'(i) : fail_first_s;
    end
  end

  // Fail summary is combinational from the registered per-channel flags.
  always_comb begin
    fail       = fail_s;
    fail_any   = |fail_s;
    fail_first = fail_first_s;
  end

endmodule

// File: tb/tb_loop_limit_mc.sv
module tb_loop_limit_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 channels, STEP 1.
  logic        reset, stop;
  logic [15:0] limit;
  logic [3:0]  load, clear_fail;
  logic [63:0] current_loop, act;
  logic [3:0]  fail;
  logic        fail_any;
  logic [1:0]  fail_first;

  // Second instance: 1 channel, STEP 7.
  logic        reset7, stop7;
  logic [15:0] limit7, seed7, act7;
  logic [0:0]  load7, clear7, fail7, first7;
  logic        any7;

  loop_limit_mc #(.WIDTH(16), .CHANNELS(4), .STEP(1)) dut (
    .clk(clk), .reset(reset), .stop(stop), .limit(limit), .load(load),
    .current_loop(current_loop), .clear_fail(clear_fail),
    .current_loop_actualize(act), .fail(fail), .fail_any(fail_any),
    .fail_first(fail_first)
  );

  loop_limit_mc #(.WIDTH(16), .CHANNELS(1), .STEP(7)) dut7 (
    .clk(clk), .reset(reset7), .stop(stop7), .limit(limit7), .load(load7),
    .current_loop(seed7), .clear_fail(clear7),
    .current_loop_actualize(act7), .fail(fail7), .fail_any(any7),
    .fail_first(first7)
  );

  typedef struct {
    int         cyc;
    bit         sel;
    logic [3:0] am;
    logic [63:0] act;
    logic [3:0] f;
    logic [1:0] ff;
  } exp_t;

  exp_t  q[$];
  string nm_q[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seed(input int ch, input logic [15:0] v);
    current_loop[ch*16 +: 16] = v;
  endtask

  task automatic exp_main(input int ofs, input string nm, input logic [3:0] am,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] a3,
                          input logic [3:0] f, input logic [1:0] ff);
    exp_t e;
    e.cyc = cyc + ofs; e.sel = 1'b0; e.am = am;
    e.act = {a3, a2, a1, a0}; e.f = f; e.ff = ff;
    q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic exp_s7(input int ofs, input string nm, input logic [15:0] a, input logic f);
    exp_t e;
    e.cyc = cyc + ofs; e.sel = 1'b1; e.am = 4'b0001;
    e.act = {48'd0, a}; e.f = {3'b000, f}; e.ff = 2'd0;
    q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: pops every expectation due this cycle and compares it.
  exp_t  m_e;
  string m_nm;
  logic  m_bad;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e  = q.pop_front();
      m_nm = nm_q.pop_front();
      vectors++;
      m_bad = (m_e.cyc != cyc);
      if (!m_e.sel) begin
        for (int c = 0; c < 4; c++) begin
          if (m_e.am[c] && act[c*16 +: 16] !== m_e.act[c*16 +: 16]) m_bad = 1'b1;
        end
        if (fail !== m_e.f || fail_any !== (|m_e.f) || fail_first !== m_e.ff) m_bad = 1'b1;
        if (m_bad) begin
          miscompares++;
          $display("FAIL %s cyc=%0d: got act=%h fail=%b any=%b first=%0d; want act=%h (mask %b) fail=%b any=%b first=%0d",
                   m_nm, cyc, act, fail, fail_any, fail_first, m_e.act, m_e.am, m_e.f, |m_e.f, m_e.ff);
        end
      end else begin
        if (act7 !== m_e.act[15:0] || fail7 !== m_e.f[0:0] || any7 !== m_e.f[0] || first7 !== 1'b0) m_bad = 1'b1;
        if (m_bad) begin
          miscompares++;
          $display("FAIL %s cyc=%0d: got act=%0d fail=%b any=%b first=%0d; want act=%0d fail=%b any=%b first=0",
                   m_nm, cyc, act7, fail7, any7, first7, m_e.act[15:0], m_e.f[0], m_e.f[0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stop = 1'b0; limit = 16'd5000; load = 4'b0000;
    clear_fail = 4'b0000; current_loop = 64'd0;
    reset7 = 1'b1; stop7 = 1'b0; limit7 = 16'd0; load7 = 1'b0; seed7 = 16'd0; clear7 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_main(0, "reset", 4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 2'd0);
    exp_main(1, "idle", 4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 2'd0);
    tick();

    // Mixed loads, one seed above the limit.
    set_seed(0, 16'd120); set_seed(1, 16'd5010); set_seed(2, 16'd456); load = 4'b0111;
    exp_main(1, "load_mix", 4'b0111, 16'd120, 16'd5000, 16'd456, 16'd0, 4'b0010, 2'd1); tick();
    load = 4'b0000;
    exp_main(1, "count_121", 4'b0111, 16'd121, 16'd5000, 16'd457, 16'd0, 4'b0010, 2'd1); tick();
    exp_main(1, "count_122", 4'b0101, 16'd122, 16'd0, 16'd458, 16'd0, 4'b0010, 2'd1); tick();

    // Count up to the limit, freeze at the limit with stop, then fail.
    set_seed(2, 16'd4998); load = 4'b0100;
    exp_main(1, "ch2_load", 4'b0101, 16'd123, 16'd0, 16'd4998, 16'd0, 4'b0010, 2'd1); tick();
    load = 4'b0000;
    exp_main(1, "ch2_4999", 4'b0101, 16'd124, 16'd0, 16'd4999, 16'd0, 4'b0010, 2'd1); tick();
    exp_main(1, "ch2_5000", 4'b0101, 16'd125, 16'd0, 16'd5000, 16'd0, 4'b0010, 2'd1); tick();
    stop = 1'b1;
    for (int k = 0; k < 27; k++) begin
      exp_main(1, "stop_freeze", 4'b0111, 16'd125, 16'd5000, 16'd5000, 16'd0, 4'b0010, 2'd1); tick();
    end
    stop = 1'b0;
    exp_main(1, "ch2_fail", 4'b0111, 16'd126, 16'd5000, 16'd5000, 16'd0, 4'b0110, 2'd1); tick();
    exp_main(1, "ch2_hold", 4'b0101, 16'd127, 16'd0, 16'd5000, 16'd0, 4'b0110, 2'd1); tick();

    // Load and clear in the same cycle: load wins.
    limit = 16'd9000; set_seed(3, 16'd8000); load = 4'b1000; clear_fail = 4'b1000;
    exp_main(1, "load_beats_clear", 4'b1001, 16'd128, 16'd0, 16'd0, 16'd8000, 4'b0110, 2'd1); tick();
    load = 4'b0000;
    exp_main(1, "clear_run", 4'b1001, 16'd129, 16'd0, 16'd0, 16'd0, 4'b0110, 2'd1); tick();
    exp_main(1, "clear_idle", 4'b1001, 16'd130, 16'd0, 16'd0, 16'd0, 4'b0110, 2'd1); tick();
    clear_fail = 4'b0000;

    // Limit dropped below a running count, then clears move fail_first.
    set_seed(0, 16'd3000); load = 4'b0001;
    exp_main(1, "ch0_3000", 4'b0001, 16'd3000, 16'd0, 16'd0, 16'd0, 4'b0110, 2'd1); tick();
    load = 4'b0000; limit = 16'd1000;
    exp_main(1, "limit_drop", 4'b0001, 16'd3000, 16'd0, 16'd0, 16'd0, 4'b0111, 2'd0); tick();
    exp_main(1, "fail_hold", 4'b0001, 16'd3000, 16'd0, 16'd0, 16'd0, 4'b0111, 2'd0); tick();
    clear_fail = 4'b0001;
    exp_main(1, "clear_ch0", 4'b0001, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0110, 2'd1); tick();
    clear_fail = 4'b0010;
    exp_main(1, "clear_ch1", 4'b0011, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0100, 2'd2); tick();
    clear_fail = 4'b0100;
    exp_main(1, "clear_ch2", 4'b1111, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 2'd0); tick();
    clear_fail = 4'b0000;

    // Zero limit, reload out of FAIL, reaching the limit exactly.
    limit = 16'd0; set_seed(0, 16'd0); set_seed(1, 16'd5); load = 4'b0011;
    exp_main(1, "lim0_load", 4'b0011, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0010, 2'd1); tick();
    load = 4'b0000;
    exp_main(1, "lim0_run_fail", 4'b0011, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0011, 2'd0); tick();
    limit = 16'd100; set_seed(0, 16'd99); load = 4'b0001;
    exp_main(1, "reload_clears", 4'b0011, 16'd99, 16'd0, 16'd0, 16'd0, 4'b0010, 2'd1); tick();
    load = 4'b0000;
    exp_main(1, "reach_limit", 4'b0001, 16'd100, 16'd0, 16'd0, 16'd0, 4'b0010, 2'd1); tick();
    exp_main(1, "fail_at_limit", 4'b0001, 16'd100, 16'd0, 16'd0, 16'd0, 4'b0011, 2'd0); tick();
    stop = 1'b1; set_seed(2, 16'd50); load = 4'b0100;
    exp_main(1, "load_ignores_stop", 4'b0100, 16'd0, 16'd0, 16'd50, 16'd0, 4'b0011, 2'd0); tick();
    load = 4'b0000;
    exp_main(1, "stopped", 4'b0100, 16'd0, 16'd0, 16'd50, 16'd0, 4'b0011, 2'd0); tick();
    stop = 1'b0;
    exp_main(1, "resume", 4'b0100, 16'd0, 16'd0, 16'd51, 16'd0, 4'b0011, 2'd0); tick();
    set_seed(3, 16'd100); load = 4'b1000;
    exp_main(1, "seed_eq_limit", 4'b1100, 16'd0, 16'd0, 16'd52, 16'd100, 4'b0011, 2'd0); tick();
    load = 4'b0000;
    exp_main(1, "eq_limit_fail", 4'b1100, 16'd0, 16'd0, 16'd53, 16'd100, 4'b1011, 2'd0); tick();

    // STEP=7 instance: clamp at the limit, reset mid-run, no wrap at the top.
    reset7 = 1'b0; limit7 = 16'd20; seed7 = 16'd15; load7 = 1'b1;
    exp_s7(1, "s7_load", 16'd15, 1'b0); tick();
    load7 = 1'b0;
    exp_s7(1, "s7_clamp", 16'd20, 1'b0); tick();
    exp_s7(1, "s7_fail", 16'd20, 1'b1); tick();
    seed7 = 16'd2; load7 = 1'b1;
    exp_s7(1, "s7_reload", 16'd2, 1'b0); tick();
    load7 = 1'b0;
    exp_s7(1, "s7_step", 16'd9, 1'b0); tick();
    reset7 = 1'b1; seed7 = 16'd5; load7 = 1'b1;
    exp_s7(1, "s7_reset", 16'd0, 1'b0); tick();
    reset7 = 1'b0; load7 = 1'b0;
    exp_s7(1, "s7_idle", 16'd0, 1'b0); tick();
    limit7 = 16'hFFFF; seed7 = 16'hFFFA; load7 = 1'b1;
    exp_s7(1, "s7_top_load", 16'hFFFA, 1'b0); tick();
    load7 = 1'b0;
    exp_s7(1, "s7_top_clamp", 16'hFFFF, 1'b0); tick();
    exp_s7(1, "s7_top_fail", 16'hFFFF, 1'b1); tick();

    // Reset of the main instance while channels are running and failed.
    reset = 1'b1;
    exp_main(1, "reset_midrun", 4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 2'd0); tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_queue: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
